serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_if.sv | 37 +++
 rtl/serial_adder_full_adder.sv | 13 +
 rtl/serial_adder.sv | 113 +++++++++++
 tb/tb_serial_adder.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between a client and serial_adder.
// The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
`ifdef SERIAL_ADDER_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
`ifdef SERIAL_ADDER_OVF_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/serial_adder_full_adder.sv
// Single-bit combinational full-adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// LSB-first bit-serial adder: one full-adder cell and a carry flop, WIDTH cycles per add.
// Optional signed-overflow output is enabled with SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic           clk,
  input logic           rst_n,
  serial_adder_if.slave bus
);

  localparam int                CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] ps_q;
  logic [WIDTH-1:0] ps_d;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;
  logic             s;
  logic             co;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q;
`endif

  full_adder u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (s),
    .co (co)
  );

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 lands at the LSB.
  assign ps_d = {s, ps_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ps_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= co;
          ps_q    <= ps_d;
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            sum_q   <= ps_d;
            cout_q  <= co;
`ifdef SERIAL_ADDER_OVF_EN
            // carry_q is the carry into the MSB on this last step
            ovf_q   <= carry_q ^ co;
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder (WIDTH=8); checks ovf only when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  // Issue one add and follow it to its done pulse; optionally poke start mid-RUN.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [7:0] e_sum, input logic e_cout, input logic e_ovf,
                        input bit poke);
    int n;
    int busy_cnt;
    int mid_bad;
    int extra_done;
    bit got;
    logic [7:0] prev;
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.cin = cin;
    @(posedge clk); #1;
    bus.start = 1'b0;
    prev = bus.sum;
    busy_cnt = bus.busy ? 1 : 0;
    mid_bad = 0; n = 0; got = 0;
    while (!got && n < 30) begin
      @(posedge clk); #1;
      n++;
      if (bus.done) got = 1;
      else begin
        if (bus.busy) busy_cnt++;
        if (bus.sum !== prev) mid_bad++;
        if (poke && n == 2) begin bus.start = 1'b1; bus.a = 8'h11; bus.b = 8'h22; end
        if (poke && n == 4) bus.start = 1'b0;
      end
    end
    $display("op a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d latency=%0d", a, b, cin, bus.sum, bus.cout, n);
    check_val("latency", n, W);
    check_val("busy_cycles", busy_cnt, W);
    check_val("sum_hold_mid_run", mid_bad, 0);
    check_val("busy_with_done", bus.busy, 1'b0);
    check_val("sum", bus.sum, e_sum);
    check_val("cout", bus.cout, e_cout);
`ifdef SERIAL_ADDER_OVF_EN
    check_val("ovf", bus.ovf, e_ovf);
`else
    if (e_ovf === 1'bx) $display("unused ovf expectation");
`endif
    @(posedge clk); #1;
    check_val("done_width", bus.done, 1'b0);
    if (poke) begin
      extra_done = 0;
      repeat (15) begin
        @(posedge clk); #1;
        if (bus.done) extra_done++;
      end
      check_val("ignored_start_no_done", extra_done, 0);
    end
  endtask

  logic [7:0] va   [6] = '{8'h3C, 8'hFF, 8'h00, 8'h7F, 8'hA5, 8'h80};
  logic [7:0] vb   [6] = '{8'h0F, 8'h01, 8'h00, 8'h01, 8'h5A, 8'h80};
  logic       vc   [6] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
  logic [7:0] vs   [6] = '{8'h4B, 8'h00, 8'h01, 8'h80, 8'h00, 8'h00};
  logic       vco  [6] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1};
  logic       vov  [6] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1};

  logic [7:0] ba   [3] = '{8'h12, 8'hF0, 8'h01};
  logic [7:0] bb   [3] = '{8'h34, 8'h20, 8'h02};
  logic       bc   [3] = '{1'b0,  1'b0,  1'b1};
  logic [7:0] bs   [3] = '{8'h46, 8'h10, 8'h04};
  logic       bco  [3] = '{1'b0,  1'b1,  1'b0};

  initial begin
    int cnt;
    int idx;
    int last_cyc;
    int hold_bad;
    int wide;
    bit prev_done;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_val("rst_busy", bus.busy, 1'b0);
    check_val("rst_done", bus.done, 1'b0);
    check_val("rst_sum", bus.sum, 8'h00);
    check_val("rst_cout", bus.cout, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run_op(va[i], vb[i], vc[i], vs[i], vco[i], vov[i], 1'b0);

    // start pulsed mid-RUN with other operands must be ignored
    run_op(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0, 1'b1);

    // Reset during RUN cycle 4 aborts with no done pulse
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h7F; bus.b = 8'h01; bus.cin = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    $display("reset mid-run: busy=%0d done=%0d sum=%02h cout=%0d", bus.busy, bus.done, bus.sum, bus.cout);
    check_val("abort_busy", bus.busy, 1'b0);
    check_val("abort_done", bus.done, 1'b0);
    check_val("abort_sum", bus.sum, 8'h00);
    check_val("abort_cout", bus.cout, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    cnt = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus.done) cnt++;
    end
    check_val("abort_no_done", cnt, 0);
    run_op(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0, 1'b0);

    // Back-to-back with start held high
    @(negedge clk);
    bus.start = 1'b1; bus.a = ba[0]; bus.b = bb[0]; bus.cin = bc[0];
    idx = 0; last_cyc = 0; hold_bad = 0; wide = 0; prev_done = 0;
    for (int cyc = 1; cyc <= 100 && idx < 3; cyc++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        if (prev_done) wide++;
        $display("b2b done %0d at cycle %0d sum=%02h cout=%0d", idx, cyc, bus.sum, bus.cout);
        check_val("b2b_sum", bus.sum, bs[idx]);
        check_val("b2b_cout", bus.cout, bco[idx]);
        if (idx > 0) check_val("b2b_period", cyc - last_cyc, W + 2);
        last_cyc = cyc;
        idx++;
        if (idx < 3) begin bus.a = ba[idx]; bus.b = bb[idx]; bus.cin = bc[idx]; end
      end else if (idx > 0 && bus.sum !== bs[idx-1]) begin
        hold_bad++;
      end
      prev_done = bus.done;
    end
    bus.start = 1'b0;
    check_val("b2b_count", idx, 3);
    check_val("b2b_sum_hold", hold_bad, 0);
    check_val("b2b_done_width", wide, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
